// File: rtl/ntt_pkg.sv
// Shared constants and FSM state encoding for the NTT feeder block.
package ntt_pkg;

    localparam int NTT_N = 16;
    localparam int NTT_Q = 7681;
    localparam int NTT_W = 32;
    localparam int IDX_W = $clog2(NTT_N);

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        STREAM,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/ntt_coef_buffer.sv
// N-entry coefficient register file: one synchronous write port and one
// asynchronous read port. Contents are not reset; every frame rewrites all
// entries before they are read.
module ntt_coef_buffer
    import ntt_pkg::*;
#(
    parameter int N  = NTT_N,
    parameter int W  = NTT_W,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [N];

    // Capture one coefficient per accepted handshake.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ntt_feeder.sv
// Upstream feeder for the 16-PE NTT systolic array. Buffers N reduced
// coefficients, resets the array while loading each PE's k index, streams
// (n, x[n]) pairs, drains the systolic pipeline and pulses done.
// Every output is a register loaded from the decode of the next state, so
// the values seen during a cycle belong to the state held in that cycle.
module ntt_feeder
    import ntt_pkg::*;
#(
    parameter int N = NTT_N,
    parameter int Q = NTT_Q,
    parameter int W = NTT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         array_rst,
    output logic [W-1:0] cfg_en_index,
    output logic [W-1:0] cfg_value,
    output logic [W-1:0] lane0,
    output logic [W-1:0] lane1,
    output logic         busy,
    output logic         done
);

    localparam int              CW         = $clog2(N);
    localparam logic [W-1:0]    Q_W        = W'(Q);
    localparam logic [CW-1:0]   LAST       = CW'(N - 1);
    localparam logic [CW-1:0]   DRAIN_LAST = CW'(N - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic [W-1:0]  rd_data;

    logic          in_ready_d, array_rst_d, busy_d, done_d;
    logic [W-1:0]  cfg_en_d, cfg_val_d, lane0_d, lane1_d;

    // Coefficients are reduced mod Q on capture so the array never sees x >= Q.
    ntt_coef_buffer #(
        .N (N),
        .W (W)
    ) u_buf (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (cnt_q),
        .wdata_i (in_data % Q_W),
        .raddr_i (cnt_d),
        .rdata_o (rd_data)
    );

    // Next-state logic: one counter sequences fill, config, stream and drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = (state_q == IDLE) && in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        state_d = CONFIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CONFIG: begin
                if (cnt_q == LAST) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // The deepest PE takes its last term N-1 cycles after the stream ends.
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state, loaded into the output registers.
    always_comb begin
        in_ready_d  = 1'b0;
        array_rst_d = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        cfg_en_d    = '0;
        cfg_val_d   = '0;
        lane0_d     = '0;
        lane1_d     = '0;
        case (state_d)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            CONFIG: begin
                array_rst_d = 1'b1;
                cfg_en_d    = W'(cnt_d) + W'(1);
                cfg_val_d   = W'(cnt_d);
            end
            STREAM: begin
                lane0_d = W'(cnt_d);
                lane1_d = rd_data;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter and registered outputs; reset holds the array cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_ready     <= 1'b0;
            array_rst    <= 1'b1;
            cfg_en_index <= '0;
            cfg_value    <= '0;
            lane0        <= '0;
            lane1        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready     <= in_ready_d;
            array_rst    <= array_rst_d;
            cfg_en_index <= cfg_en_d;
            cfg_value    <= cfg_val_d;
            lane0        <= lane0_d;
            lane1        <= lane1_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_ntt_feeder.sv
// Testbench for ntt_feeder: random and directed frames checked against a
// frame-level reference (expected trace per cycle after the last accept and
// a direct NTT sum mod Q for every PE bin).
module tb_ntt_feeder;

    localparam int     N    = 16;
    localparam int     Q    = 7681;
    localparam int     W    = 32;
    localparam longint ROOT = 7098;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         array_rst;
    logic [W-1:0] cfg_en_index;
    logic [W-1:0] cfg_value;
    logic [W-1:0] lane0;
    logic [W-1:0] lane1;
    logic         busy;
    logic         done;

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned coef_src [N];
    longint      pe_obs   [N];
    int          fill_cycles;

    always #5 clk = ~clk;

    ntt_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .array_rst    (array_rst),
        .cfg_en_index (cfg_en_index),
        .cfg_value    (cfg_value),
        .lane0        (lane0),
        .lane1        (lane1),
        .busy         (busy),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint powmod(input longint b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // One frame: fill with the given valid pattern, then check the 3N-cycle
    // trace that must follow the last accept. abort_i > 0 asserts rst at that
    // trace cycle and checks the reset values instead of finishing the frame.
    task automatic run_frame(input int mode, input int abort_i);
        int     acc;
        int     guard;
        logic   v;
        logic   rdy;
        longint expv [N];
        longint pe_exp;
        int     t;
        logic [3:0]  ectl;
        logic [63:0] ecfg;
        logic [63:0] elane;
        acc   = 0;
        guard = 0;
        for (int k = 0; k < N; k++) begin
            pe_obs[k] = 0;
            expv[k]   = 0;
        end
        while (acc < N && guard < 2000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            rdy      = in_ready;
            in_valid = v;
            in_data  = coef_src[acc];
            if (rdy) check_eq("idle_ctl", 64'({array_rst, busy, done}), 64'(3'b000));
            @(negedge clk);
            if (v && rdy) begin
                expv[acc] = longint'(coef_src[acc] % Q);
                acc++;
            end
            guard++;
        end
        fill_cycles = guard;
        check_eq("accepts", 64'(acc), 64'(N));
        for (int i = 1; i <= 3 * N; i++) begin
            in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_data  = $urandom;
            ecfg  = '0;
            elane = '0;
            if (i <= N) begin
                ectl = 4'b1100;
                ecfg = {32'(i), 32'(i - 1)};
            end else if (i <= 2 * N) begin
                t     = i - N - 1;
                ectl  = 4'b0100;
                elane = {32'(t), 32'(expv[t])};
            end else if (i < 3 * N) begin
                ectl = 4'b0100;
            end else begin
                ectl = 4'b0110;
            end
            check_eq($sformatf("ctl@%0d", i), 64'({array_rst, busy, done, in_ready}), 64'(ectl));
            check_eq($sformatf("cfg@%0d", i), {cfg_en_index, cfg_value}, ecfg);
            check_eq($sformatf("lane@%0d", i), {lane0, lane1}, elane);
            if (i > N && i <= 2 * N && lane0 < N) begin
                for (int k = 0; k < N; k++)
                    pe_obs[k] = (pe_obs[k] + (longint'(lane1) % Q) * powmod(ROOT, int'(lane0) * k)) % Q;
            end
            if (i == abort_i) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check_eq("abort_ctl", 64'({array_rst, busy, done, in_ready}), 64'(4'b1000));
                check_eq("abort_cfg", {cfg_en_index, cfg_value}, 64'(0));
                check_eq("abort_lane", {lane0, lane1}, 64'(0));
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("post_done_ctl", 64'({array_rst, busy, done, in_ready}), 64'(4'b0001));
        for (int k = 0; k < N; k++) begin
            pe_exp = 0;
            for (int n = 0; n < N; n++) pe_exp = (pe_exp + expv[n] * powmod(ROOT, n * k)) % Q;
            check_eq($sformatf("pe%0d", k), 64'(pe_obs[k]), 64'(pe_exp));
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < N; n++) begin
            case ($urandom_range(0, 3))
                0:       coef_src[n] = $urandom;
                1:       coef_src[n] = $urandom_range(0, Q - 1);
                2:       coef_src[n] = Q + $urandom_range(0, 2);
                default: coef_src[n] = 32'hFFFF_FFFF - $urandom_range(0, 15);
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", 64'({array_rst, busy, done, in_ready}), 64'(4'b1000));
        check_eq("rst_cfg", {cfg_en_index, cfg_value}, 64'(0));
        check_eq("rst_lane", {lane0, lane1}, 64'(0));
        rst = 1'b0;

        // Frame 1..16 followed immediately by 16..1.
        for (int n = 0; n < N; n++) coef_src[n] = n + 1;
        run_frame(0, 0);
        check_eq("pe0_sum_a", 64'(pe_obs[0]), 64'(136));
        for (int n = 0; n < N; n++) coef_src[n] = N - n;
        run_frame(0, 0);
        check_eq("b2b_fill", 64'(fill_cycles), 64'(N));
        check_eq("pe0_sum_b", 64'(pe_obs[0]), 64'(136));

        // Q+1 everywhere reduces to 1; toggled valid.
        for (int n = 0; n < N; n++) coef_src[n] = Q + 1;
        run_frame(1, 0);
        check_eq("pe0_q1", 64'(pe_obs[0]), 64'(16));

        // Reset in stream cycle t=5, then an all-zero frame.
        fill_random();
        coef_src[0] = Q;
        run_frame(2, N + 6);
        for (int n = 0; n < N; n++) coef_src[n] = 0;
        run_frame(2, 0);

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(2, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ntt_feeder.md
Name: ntt_feeder

Overview:
- Upstream stage of the 16-PE NTT systolic array (modulus 7681).
- Accepts N coefficients over a valid/ready stream and buffers them.
- Drives the array's reset and its per-PE internal-register (k index) load sequence, then streams index/coefficient pairs on lane0/lane1.
- Flushes the pipeline and pulses done once every PE accumulator holds its final value.

Parameters:
N, 16, transform length = number of PEs in the array
Q, 7681, modulus; coefficients are reduced mod Q on capture
W, 32, data width of all lanes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data  in  W  coefficient
in_valid  in  1  coefficient valid
in_ready  out  1  feeder can accept a coefficient
array_rst  out  1  reset to the array (clears PEValue, loads twiddles)
cfg_en_index  out  W  InternalRegisterEnableIndex; 0 = none, 1..N selects PE k-1
cfg_value  out  W  InternalRegisterInputValue0
lane0  out  W  Dim0InputLane0 (sample index n)
lane1  out  W  Dim0InputLane1 (coefficient x[n])
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; array PEValues are final

Behaviour:
- Reset values: in_ready=0, array_rst=1, cfg_en_index=0, cfg_value=0, lane0=0, lane1=0, busy=0, done=0. Fill count=0, state=IDLE.
- All outputs are registered. The values listed per state hold during the cycles the FSM is in that state.
- IDLE (fill):
  - in_ready=1, array_rst=0.
  - Handshake when in_valid and in_ready: buf[cnt] <= in_data % Q, cnt++.
  - When the N-th coefficient is accepted, the next cycle is CONFIG.
  - in_valid with in_ready=0 is ignored; no data is lost or captured.
- CONFIG (N cycles, c=0..N-1):
  - array_rst=1, cfg_en_index=c+1, cfg_value=c, in_ready=0, busy=1, lanes=0.
- STREAM (N cycles, t=0..N-1):
  - array_rst=0, cfg_en_index=0, lane0=t, lane1=buf[t].
- DRAIN (N-1 cycles): lane0=lane1=0.
  - PE k accumulates element t on the edge ending stream cycle t+k.
  - The last accumulation (t=k=N-1) occurs on the edge ending DRAIN cycle N-2.
- DONE (1 cycle): done=1, lanes=0, busy=1. Then IDLE with cnt=0 and in_ready=1.
- Latency from the last accepted coefficient to done: 3N cycles (N CONFIG + N STREAM + N-1 DRAIN + 1 DONE).
- Width rules:
  - Capture reduction is an unsigned W-bit modulo.
  - Stored coefficients are < Q, so lane1·twiddle fits in W bits.
  - Counters are $clog2(N) bits, zero-extended onto the W-bit outputs.
- Boundary conditions:
  - rst mid-operation (any state): immediate return to reset values. Buffer contents are don't-care, cnt=0. array_rst=1 holds the array cleared until the next CONFIG.
  - in_valid held continuously: N accepts on N consecutive cycles, then in_ready drops the cycle after the N-th accept.
  - Coefficient = Q or ≥ Q: stored reduced (Q→0, Q+1→1).
  - done and in_ready are never high in the same cycle.

Decomposition:
- Shared package ntt_pkg holds:
  - constants NTT_N=16, NTT_Q=7681, NTT_W=32;
  - state enum {IDLE, CONFIG, STREAM, DRAIN, DONE};
  - localparam IDX_W=$clog2(NTT_N).
- One natural sub-module, ntt_coef_buffer: an N-entry register file with a write port (addr, data, we) and an asynchronous read port, instantiated by the feeder.
- The mod-Q reduction stays inline at the buffer write.

Test Plan:
- Coefficients 1..16 streamed back-to-back into feeder+array:
  - done fires 48 cycles after the 16th accept;
  - PE0 value = 136 (sum, k=0);
  - all PEValues match a software NTT mod 7681 with root 7098.
- Trace checks during one frame:
  - CONFIG shows cfg_en_index 1..16 with cfg_value 0..15 and array_rst=1;
  - STREAM shows lane0 0..15, lane1=buffer, cfg_en_index=0;
  - DRAIN lasts 15 cycles.
- Input 7682 for all 16 samples → PE0 = 16; every lane1 in STREAM = 1.
- in_valid toggled 1/0 every other cycle: exactly 16 accepts; CONFIG entered the cycle after the 16th; in_valid during busy raises no in_ready.
- rst asserted in STREAM cycle t=5:
  - next cycle array_rst=1, busy=0, lanes=0;
  - a fresh frame of all-zero coefficients then gives every PE = 0.
- Two frames back-to-back (1..16, then 16..1): second frame accepted immediately after done; second done gives PE0 = 136 and the correct remaining bins; no carry-over from frame 1.
